cacc_dlv_rd_pipe: RTL and testbench

Read-side pipeline between the CACC delivery controller and SDP. It accepts read requests (address plus layer-end tag) from the delivery controller and issues them to the delivery buffer RAM, which has a fixed read latency. Returned data is captured into a small output FIFO and presented to SDP on a valid/ready handshake. Flow control is credit-based, so no RAM data is ever dropped when SDP stalls.

---
 rtl/cacc_dlv_rd_pipe_if.sv | 30 +++
 rtl/cacc_dlv_rd_pipe.sv | 143 ++++++++++++++
 tb/tb_cacc_dlv_rd_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cacc_dlv_rd_pipe_if.sv
// rtl/cacc_dlv_rd_pipe_if.sv - request, RAM and SDP signal bundle for the CACC delivery read pipe
interface cacc_dlv_rd_pipe_if #(
    parameter int DW = 512,
    parameter int AW = 6
);
    logic          dbuf_rd_en;
    logic [AW-1:0] dbuf_rd_addr;
    logic          dbuf_rd_layer_end;
    logic          dbuf_rd_ready;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          cacc2sdp_valid;
    logic          cacc2sdp_ready;
    logic [DW:0]   cacc2sdp_pd;
    logic          dlv_layer_done;
    logic [31:0]   dlv_stall_cnt;

    modport slave (
        input  dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, ram_rd_data, cacc2sdp_ready,
        output dbuf_rd_ready, ram_rd_en, ram_rd_addr, cacc2sdp_valid, cacc2sdp_pd,
               dlv_layer_done, dlv_stall_cnt
    );

    modport master (
        output dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, ram_rd_data, cacc2sdp_ready,
        input  dbuf_rd_ready, ram_rd_en, ram_rd_addr, cacc2sdp_valid, cacc2sdp_pd,
               dlv_layer_done, dlv_stall_cnt
    );
endinterface

// File: rtl/cacc_dlv_rd_pipe.sv
// rtl/cacc_dlv_rd_pipe.sv - credit-controlled RAM read pipe feeding SDP through an output FIFO
// Optional stall counter: NVDLA_CACC_DLV_STALL_CNT_EN.
module cacc_dlv_rd_pipe #(
    parameter int DW        = 512,
    parameter int AW        = 6,
    parameter int RD_LAT    = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    cacc_dlv_rd_pipe_if.slave    io
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [CW-1:0]        crd_q, crd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0]    vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]    le_pipe_q, le_pipe_d;
    logic [DW-1:0]        dat_mem_q [OUT_DEPTH];
    logic [DW-1:0]        dat_mem_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] le_mem_q, le_mem_d;
    logic                 layer_done_q, layer_done_d;

    logic acc, push, pop, rd_ready, out_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready looks only at the registered credit so it never depends on dbuf_rd_en or the current pop.
    assign rd_ready  = (crd_q < CW'(OUT_DEPTH));
    assign acc       = io.dbuf_rd_en & rd_ready;
    assign push      = vld_pipe_q[RD_LAT-1];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & io.cacc2sdp_ready;

    assign io.dbuf_rd_ready  = rd_ready;
    assign io.ram_rd_en      = acc;
    assign io.ram_rd_addr    = io.dbuf_rd_addr;
    assign io.cacc2sdp_valid = out_valid;
    assign io.cacc2sdp_pd    = {le_mem_q[rd_ptr_q], dat_mem_q[rd_ptr_q]};
    assign io.dlv_layer_done = layer_done_q;

    always_comb begin
        vld_pipe_d    = '0;
        le_pipe_d     = '0;
        vld_pipe_d[0] = acc;
        le_pipe_d[0]  = acc & io.dbuf_rd_layer_end;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            le_pipe_d[i]  = le_pipe_q[i-1];
        end
    end

    always_comb begin
        crd_d = crd_q;
        case ({acc, pop})
            2'b10:   crd_d = crd_q + CW'(1);
            2'b01:   crd_d = crd_q - CW'(1);
            default: crd_d = crd_q;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dat_mem_d = dat_mem_q;
        le_mem_d  = le_mem_q;
        if (push) begin
            dat_mem_d[wr_ptr_q] = io.ram_rd_data;
            le_mem_d[wr_ptr_q]  = le_pipe_q[RD_LAT-1];
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        layer_done_d = pop & io.cacc2sdp_pd[DW];
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            crd_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            vld_pipe_q   <= '0;
            le_pipe_q    <= '0;
            le_mem_q     <= '0;
            layer_done_q <= 1'b0;
        end else begin
            crd_q        <= crd_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            vld_pipe_q   <= vld_pipe_d;
            le_pipe_q    <= le_pipe_d;
            le_mem_q     <= le_mem_d;
            layer_done_q <= layer_done_d;
        end
    end

    // Payload storage carries no reset; occupancy and pointers decide what is visible.
    always_ff @(posedge nvdla_core_clk) begin
        dat_mem_q <= dat_mem_d;
    end

`ifdef NVDLA_CACC_DLV_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (layer_done_q) begin
            stall_cnt_d = '0;
        end else if (out_valid & ~io.cacc2sdp_ready & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io.dlv_stall_cnt = stall_cnt_q;
`else
    assign io.dlv_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_cacc_dlv_rd_pipe.sv
// tb/tb_cacc_dlv_rd_pipe.sv - self-checking bench for cacc_dlv_rd_pipe
module tb_cacc_dlv_rd_pipe;
    localparam int DW = 512;
    localparam int AW = 6;
    localparam int RD_LAT = 2;
    localparam int OUT_DEPTH = 4;
`ifdef NVDLA_CACC_DLV_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cacc_dlv_rd_pipe_if #(.DW(DW), .AW(AW)) bus ();

    cacc_dlv_rd_pipe #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .io             (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] ram_mem [64];
    logic [DW-1:0] ram_pipe [RD_LAT];
    assign bus.ram_rd_data = ram_pipe[RD_LAT-1];

    always @(posedge clk) begin
        ram_pipe[0] <= bus.ram_rd_en ? ram_mem[bus.ram_rd_addr] : {DW{1'b1}};
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    // Reference model: every accepted request becomes one beat, due RD_LAT+1 cycles later, delivered in order.
    typedef struct {
        int          t;
        logic [DW:0] pd;
    } exp_t;
    exp_t        q[$];
    int          cyc = 0;
    int          m_crd = 0;
    logic        p_hs_le = 1'b0;
    logic        p_v = 1'b0;
    logic        p_r = 1'b1;
    logic [DW:0] p_pd;
    logic [31:0] m_stall = 32'd0;

    always @(negedge clk) begin
        logic exp_v, acc, hs, hs_le;
        if (!rstn) begin
            q.delete();
            m_crd = 0; p_hs_le = 1'b0; p_v = 1'b0; p_r = 1'b1; m_stall = 32'd0;
        end else begin
            chk("mon_ready", bus.dbuf_rd_ready, m_crd < OUT_DEPTH);
            acc = bus.dbuf_rd_en && (m_crd < OUT_DEPTH);
            chk("mon_ram_en", bus.ram_rd_en, acc);
            if (acc) chk("mon_ram_addr", bus.ram_rd_addr, bus.dbuf_rd_addr);
            exp_v = (q.size() > 0) && (q[0].t <= cyc);
            chk("mon_valid", bus.cacc2sdp_valid, exp_v);
            if (exp_v) chk("mon_pd", bus.cacc2sdp_pd, q[0].pd);
            if (p_v && !p_r) begin
                chk("mon_hold_valid", bus.cacc2sdp_valid, 1'b1);
                chk("mon_hold_pd", bus.cacc2sdp_pd, p_pd);
            end
            chk("mon_done", bus.dlv_layer_done, p_hs_le);
            chk("mon_stall", bus.dlv_stall_cnt, m_stall);
            hs = exp_v && bus.cacc2sdp_ready;
            hs_le = hs && q[0].pd[DW];
            if (STALL_EN) begin
                if (p_hs_le) m_stall = 32'd0;
                else if (exp_v && !bus.cacc2sdp_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            end
            if (hs) void'(q.pop_front());
            if (acc) q.push_back('{cyc + RD_LAT + 1, {bus.dbuf_rd_layer_end, ram_mem[bus.dbuf_rd_addr]}});
            m_crd = m_crd + int'(acc) - int'(hs);
            p_hs_le = hs_le;
            p_v = bus.cacc2sdp_valid;
            p_r = bus.cacc2sdp_ready;
            p_pd = bus.cacc2sdp_pd;
        end
        cyc++;
    end

    task automatic drive(input logic en, input logic [AW-1:0] addr, input logic le, input logic rdy);
        @(posedge clk);
        #1;
        bus.dbuf_rd_en = en;
        bus.dbuf_rd_addr = addr;
        bus.dbuf_rd_layer_end = le;
        bus.cacc2sdp_ready = rdy;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
        end
        chk(name, q.size(), 0);
    endtask

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic          le;
        logic          rdy;
        logic          e_ready;
        logic          e_ram_en;
        logic          e_valid;
        logic          e_le;
        logic          e_done;
    } vec_t;

    vec_t vecs[6];
    int   n, k, dones;
    logic [DW-1:0] a5;

    initial begin
        vecs[0] = '{1'b1, 6'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 64; i++)
            for (int w = 0; w < DW / 32; w++) ram_mem[i][w*32 +: 32] = $urandom;
        a5 = {(DW / 8){8'hA5}};
        ram_mem[5] = a5;

        bus.dbuf_rd_en = 1'b0; bus.dbuf_rd_addr = '0; bus.dbuf_rd_layer_end = 1'b0; bus.cacc2sdp_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.dbuf_rd_ready, 1'b1);
        chk("rst_ram_en", bus.ram_rd_en, 1'b0);
        chk("rst_valid", bus.cacc2sdp_valid, 1'b0);
        chk("rst_done", bus.dlv_layer_done, 1'b0);
        chk("rst_stall", bus.dlv_stall_cnt, 32'd0);
        chk("rst_pd_le", bus.cacc2sdp_pd[DW], 1'b0);

        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].en, vecs[i].addr, vecs[i].le, vecs[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), bus.dbuf_rd_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_ram_en", i), bus.ram_rd_en, vecs[i].e_ram_en);
            chk($sformatf("vec%0d_valid", i), bus.cacc2sdp_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_done", i), bus.dlv_layer_done, vecs[i].e_done);
            if (vecs[i].e_valid) chk($sformatf("vec%0d_pd", i), bus.cacc2sdp_pd, {vecs[i].e_le, a5});
            if (bus.ram_rd_en) n++;
        end
        chk("single_ram_reads", n, 1);
        drain("single_drain");

        for (int c = 0; c < 20; c++) begin
            drive(c < 16, AW'(c), 1'b0, 1'b1);
            @(negedge clk);
            if (c < 16) chk("b2b_ready", bus.dbuf_rd_ready, 1'b1);
            chk("b2b_valid", bus.cacc2sdp_valid, (c >= 3) && (c < 19));
        end
        drain("b2b_drain");

        n = 0;
        for (int c = 0; c < 22; c++) begin
            drive(1'b1, AW'(32 + c), 1'b0, c >= 13);
            @(negedge clk);
            if (c <= 12 && bus.ram_rd_en) n++;
            if (c == 4) chk("stall_ready_low", bus.dbuf_rd_ready, 1'b0);
            if (c == 13) chk("stall_cnt", bus.dlv_stall_cnt, STALL_EN ? 32'd10 : 32'd0);
        end
        chk("stall_reads", n, OUT_DEPTH);
        drain("stall_drain");

        for (int c = 0; c < 11; c++) begin
            drive(1'b1, AW'(40 + c), 1'b0, c == 8);
            @(negedge clk);
            if (c == 8) begin
                chk("full_ready_P", bus.dbuf_rd_ready, 1'b0);
                chk("full_valid_P", bus.cacc2sdp_valid, 1'b1);
            end
            if (c == 9) begin
                chk("full_ready_P1", bus.dbuf_rd_ready, 1'b1);
                chk("full_ram_en_P1", bus.ram_rd_en, 1'b1);
            end
            if (c == 10) chk("full_ready_P2", bus.dbuf_rd_ready, 1'b0);
        end
        drain("full_drain");

        for (int c = 0; c < 4; c++) begin
            drive(1'b1, AW'(50 + c), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            rstn = 1'b1;
            @(negedge clk);
            chk("rstmid_valid", bus.cacc2sdp_valid, 1'b0);
            chk("rstmid_ready", bus.dbuf_rd_ready, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 6'd9, 1'b1, 1'b1);
            @(negedge clk);
            if (c == 3) begin
                chk("rstmid_new_valid", bus.cacc2sdp_valid, 1'b1);
                chk("rstmid_new_pd", bus.cacc2sdp_pd, {1'b1, ram_mem[9]});
            end
            if (c == 4) chk("rstmid_new_done", bus.dlv_layer_done, 1'b1);
        end
        drain("rstmid_drain");

        k = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            drive(k < 8, AW'(20 + k), k == 7, c[0]);
            @(negedge clk);
            if (bus.dbuf_rd_en && bus.dbuf_rd_ready) k++;
            if (bus.dlv_layer_done) dones++;
        end
        chk("toggle_accepted", k, 8);
        chk("toggle_done_pulses", dones, 1);
        drain("toggle_drain");

        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
